// File: rtl/entry_gate_controller.sv
// Entry-lane front end: conditions loop sensors, classifies the car by badge,
// drives the barrier arm and reports one clean entry pulse per admitted car.

module entry_gate_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic start,
  input  logic raw,
  output logic level
);
  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer, then accept a new level after CYCLES stable samples.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(CYCLES - 1)) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module entry_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BADGE_WINDOW    = 16,
  parameter int unsigned OPEN_TIMEOUT    = 64,
  parameter int unsigned CLOSE_CYCLES    = 8
) (
  input  logic clk,
  input  logic start,
  input  logic loop_arrive,
  input  logic loop_pass,
  input  logic badge_valid,
  input  logic uni_space_ok,
  input  logic gen_space_ok,
  output logic gate_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic reject,
  output logic timeout_abort,
  output logic busy
);
  localparam int unsigned WIN_W   = $clog2(BADGE_WINDOW + 1);
  localparam int unsigned OPEN_W  = $clog2(OPEN_TIMEOUT + 1);
  localparam int unsigned CLOSE_W = $clog2(CLOSE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_OPEN,
    S_PASSING,
    S_CLOSING,
    S_REJECT
  } state_t;

  state_t state;
  state_t state_next;

  logic               arrive_db;
  logic               pass_db;
  logic               arrive_q;
  logic               pass_q;
  logic               uni_flag;
  logic               uni_now;
  logic               open_restart;
  logic [WIN_W-1:0]   win_cnt;
  logic [OPEN_W-1:0]  open_cnt;
  logic [CLOSE_W-1:0] close_cnt;

  entry_gate_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_arrive (
    .clk   (clk),
    .start (start),
    .raw   (loop_arrive),
    .level (arrive_db)
  );

  entry_gate_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_pass (
    .clk   (clk),
    .start (start),
    .raw   (loop_pass),
    .level (pass_db)
  );

  wire arrive_rise = arrive_db & ~arrive_q;
  wire pass_rise   = pass_db & ~pass_q;
  wire pass_fall   = ~pass_db & pass_q;
  wire win_last    = (win_cnt == WIN_W'(BADGE_WINDOW - 1));
  wire open_last   = (open_cnt == OPEN_W'(OPEN_TIMEOUT - 1));
  wire close_last  = (close_cnt == CLOSE_W'(CLOSE_CYCLES - 1));

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A badge arriving in the decision cycle itself still selects the uni pool.
  always_comb begin
    state_next   = state;
    open_restart = 1'b0;
    uni_now      = uni_flag | badge_valid;
    case (state)
      S_IDLE: begin
        if (arrive_rise) state_next = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (win_last) begin
          if (uni_now ? uni_space_ok : gen_space_ok) state_next = S_OPEN;
          else                                       state_next = S_REJECT;
        end
      end
      S_OPEN: begin
        if (pass_rise) begin
          state_next = S_PASSING;
        end else if (open_last) begin
          if (arrive_db) open_restart = 1'b1;
          else           state_next   = S_CLOSING;
        end
      end
      S_PASSING: begin
        if (pass_fall) state_next = S_CLOSING;
      end
      S_CLOSING: begin
        if (close_last) state_next = S_IDLE;
      end
      S_REJECT: begin
        if (!arrive_db) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state counters rest at zero outside their state and saturate inside it.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      win_cnt   <= '0;
      open_cnt  <= '0;
      close_cnt <= '0;
      uni_flag  <= 1'b0;
      arrive_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      arrive_q <= arrive_db;
      pass_q   <= pass_db;

      if (state != S_CLASSIFY)                     win_cnt <= '0;
      else if (win_cnt != WIN_W'(BADGE_WINDOW))    win_cnt <= win_cnt + WIN_W'(1);

      if (state != S_OPEN || open_restart)         open_cnt <= '0;
      else if (open_cnt != OPEN_W'(OPEN_TIMEOUT))  open_cnt <= open_cnt + OPEN_W'(1);

      if (state != S_CLOSING)                      close_cnt <= '0;
      else if (close_cnt != CLOSE_W'(CLOSE_CYCLES)) close_cnt <= close_cnt + CLOSE_W'(1);

      if (state == S_IDLE)                          uni_flag <= 1'b0;
      else if (state == S_CLASSIFY && badge_valid) uni_flag <= 1'b1;
    end
  end

  // Outputs are registered from the next state so they align with state entry.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      gate_open          <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      reject             <= 1'b0;
      timeout_abort      <= 1'b0;
      busy               <= 1'b0;
    end else begin
      gate_open          <= (state_next == S_OPEN) || (state_next == S_PASSING);
      car_entered        <= (state == S_OPEN) && (state_next == S_PASSING);
      is_uni_car_entered <= (state == S_OPEN) && (state_next == S_PASSING) && uni_flag;
      reject             <= (state == S_CLASSIFY) && (state_next == S_REJECT);
      timeout_abort      <= (state == S_OPEN) && (state_next == S_CLOSING);
      busy               <= (state_next != S_IDLE);
    end
  end
endmodule

// File: tb/tb_entry_gate_controller.sv
// Scoreboard bench: each scenario pushes per-cycle expected output vectors,
// a negedge monitor pops and compares them against the DUT.

module tb_entry_gate_controller;
  logic clk = 1'b0;
  logic start = 1'b0;
  logic loop_arrive = 1'b0;
  logic loop_pass = 1'b0;
  logic badge_valid = 1'b0;
  logic uni_space_ok = 1'b0;
  logic gen_space_ok = 1'b0;
  logic gate_open, car_entered, is_uni_car_entered, reject, timeout_abort, busy;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];

  entry_gate_controller dut (
    .clk                (clk),
    .start              (start),
    .loop_arrive        (loop_arrive),
    .loop_pass          (loop_pass),
    .badge_valid        (badge_valid),
    .uni_space_ok       (uni_space_ok),
    .gen_space_ok       (gen_space_ok),
    .gate_open          (gate_open),
    .car_entered        (car_entered),
    .is_uni_car_entered (is_uni_car_entered),
    .reject             (reject),
    .timeout_abort      (timeout_abort),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_span(input string tag, input int c0, input int c1, input logic [5:0] v);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc = c;
      e.vec = v;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Vector bits: {busy, gate_open, car_entered, is_uni, reject, timeout_abort}
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_vec($sformatf("%s@%0d(now %0d)", e.tag, e.cyc, cyc),
                32'({busy, gate_open, car_entered, is_uni_car_entered, reject, timeout_abort}),
                32'(e.vec));
    end
  end

  task automatic uni_admit(input int r, output int fin);
    int a;
    a = r + 6;
    uni_space_ok = 1'b1;
    gen_space_ok = 1'b0;
    push_span("ua_idle",     r,      a,      6'b000000);
    push_span("ua_classify", a + 1,  a + 16, 6'b100000);
    push_span("ua_open",     a + 17, a + 26, 6'b110000);
    push_span("ua_enter",    a + 27, a + 27, 6'b111100);
    push_span("ua_passing",  a + 28, a + 38, 6'b110000);
    push_span("ua_closing",  a + 39, a + 46, 6'b100000);
    push_span("ua_done",     a + 47, a + 60, 6'b000000);
    goto(r);      loop_arrive = 1'b1;
    goto(a + 5);  badge_valid = 1'b1;
    goto(a + 6);  badge_valid = 1'b0;
    goto(a + 20); loop_pass = 1'b1;
    goto(a + 32); loop_pass = 1'b0;
    goto(a + 50); loop_arrive = 1'b0;
    goto(a + 60);
    fin = a + 60;
  endtask

  task automatic gen_full(input int r, output int fin);
    int a;
    a = r + 6;
    uni_space_ok = 1'b1;
    gen_space_ok = 1'b0;
    push_span("gf_idle",     r,      a,      6'b000000);
    push_span("gf_classify", a + 1,  a + 16, 6'b100000);
    push_span("gf_reject",   a + 17, a + 17, 6'b100010);
    push_span("gf_hold",     a + 18, a + 31, 6'b100000);
    push_span("gf_done",     a + 32, a + 36, 6'b000000);
    goto(r);      loop_arrive = 1'b1;
    goto(a + 25); loop_arrive = 1'b0;
    goto(a + 36);
    fin = a + 36;
  endtask

  task automatic bounce_timeout(input int r, output int fin);
    int a;
    a = r + 26;
    uni_space_ok = 1'b0;
    gen_space_ok = 1'b1;
    push_span("bt_bounce",   r,      a,      6'b000000);
    push_span("bt_classify", a + 1,  a + 16, 6'b100000);
    push_span("bt_open",     a + 17, a + 80, 6'b110000);
    push_span("bt_abort",    a + 81, a + 81, 6'b100001);
    push_span("bt_closing",  a + 82, a + 88, 6'b100000);
    push_span("bt_done",     a + 89, a + 92, 6'b000000);
    for (int c = 0; c < 20; c++) begin
      goto(r + c);
      loop_arrive = ((c / 2) % 2) == 0;
    end
    goto(r + 20); loop_arrive = 1'b1;
    goto(a + 10); loop_arrive = 1'b0;
    goto(a + 92);
    fin = a + 92;
  endtask

  task automatic late_badge_reset(input int r, output int fin);
    int a;
    a = r + 6;
    uni_space_ok = 1'b1;
    gen_space_ok = 1'b0;
    push_span("lb_idle",     r,      a,      6'b000000);
    push_span("lb_classify", a + 1,  a + 16, 6'b100000);
    push_span("lb_open",     a + 17, a + 26, 6'b110000);
    push_span("lb_enter",    a + 27, a + 27, 6'b111100);
    push_span("lb_passing",  a + 28, a + 29, 6'b110000);
    push_span("lb_reset",    a + 30, a + 45, 6'b000000);
    goto(r);      loop_arrive = 1'b1;
    goto(a + 16); badge_valid = 1'b1;
    goto(a + 17); badge_valid = 1'b0;
    goto(a + 20); loop_pass = 1'b1;
    goto(a + 30);
    start = 1'b0;
    loop_arrive = 1'b0;
    loop_pass = 1'b0;
    goto(a + 33); start = 1'b1;
    goto(a + 45);
    fin = a + 45;
  endtask

  initial begin
    int t;
    push_span("reset", 1, 8, 6'b000000);
    goto(3);
    start = 1'b1;
    goto(8);
    uni_admit(20, t);
    gen_full(t + 5, t);
    bounce_timeout(t + 5, t);
    late_badge_reset(t + 5, t);
    goto(t + 3);
    check_vec("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
